// File: rtl/uart_tx_framed.sv
// UART serialiser: start, DATA_BITS payload (LSB first), optional parity, STOP_BITS stop bits.
// Parity bit and PARITY state exist only when UART_TX_PARITY_EN is defined.
module uart_tx_framed #(
  parameter int CYCLES    = 10416,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 parity_odd,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic                 out
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam int BW = 3;

  if (CYCLES < 2 || DATA_BITS < 5 || DATA_BITS > 8 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
    $error("uart_tx_framed: illegal CYCLES, DATA_BITS or STOP_BITS");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4
  } state_t;
`endif

  state_t               state_q, state_d;
  logic [CW-1:0]        cyc_q, cyc_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 out_q, out_d;
  logic                 done_q, done_d;
  logic                 slot_end;

`ifdef UART_TX_PARITY_EN
  logic                 odd_q, odd_d;
`else
  logic                 unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  assign slot_end = (cyc_q == CW'(CYCLES - 1));

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    data_d  = data_q;
    out_d   = out_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    odd_d   = odd_q;
`endif
    // Every non-idle state is a sequence of CYCLES-long slots.
    if (state_q != IDLE) begin
      cyc_d = slot_end ? '0 : cyc_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        out_d = 1'b1;
        cyc_d = '0;
        if (valid) begin
          state_d = START;
          data_d  = data;
`ifdef UART_TX_PARITY_EN
          odd_d   = parity_odd;
`endif
          bit_d   = '0;
          out_d   = 1'b0;
        end
      end
      START: begin
        if (slot_end) begin
          state_d = DATA;
          bit_d   = '0;
          out_d   = data_q[0];
        end
      end
      DATA: begin
        if (slot_end) begin
          if (bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            out_d   = (^data_q) ^ odd_q;
`else
            state_d = STOP;
            bit_d   = '0;
            out_d   = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
            out_d = data_q[bit_d];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (slot_end) begin
          state_d = STOP;
          bit_d   = '0;
          out_d   = 1'b1;
        end
      end
`endif
      STOP: begin
        out_d = 1'b1;
        if (slot_end) begin
          if (bit_q == BW'(STOP_BITS - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = '0;
        bit_d   = '0;
        out_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      out_q   <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      odd_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      out_q   <= out_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      odd_q   <= odd_d;
`endif
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = ~ready;
  assign done  = done_q;
  assign out   = out_q;

endmodule

// File: tb/tb_uart_tx_framed.sv
// Bench for uart_tx_framed: slot-arithmetic frame model checked every cycle, plus literal frame checks.
module tb_uart_tx_framed;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LEN_A = (1 + 8 + PB + 1) * C;
  localparam int LEN_B = (1 + 7 + PB + 2) * C;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_a, odd_a, ready_a, busy_a, done_a, out_a;
  logic [7:0] data_a;
  logic       valid_b, odd_b, ready_b, busy_b, done_b, out_b;
  logic [6:0] data_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_framed #(.CYCLES(C), .DATA_BITS(8), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .valid(valid_a), .data(data_a), .parity_odd(odd_a),
    .ready(ready_a), .busy(busy_a), .done(done_a), .out(out_a));

  uart_tx_framed #(.CYCLES(C), .DATA_BITS(7), .STOP_BITS(2)) u_b (
    .clk(clk), .rst_n(rst_n), .valid(valid_b), .data(data_b), .parity_odd(odd_b),
    .ready(ready_b), .busy(busy_b), .done(done_b), .out(out_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line level of frame slot 'slot' for payload d of db bits.
  function automatic logic slot_val(input logic [7:0] d, input int db, input logic odd, input int slot);
    logic par;
    par = odd;
    for (int i = 0; i < db; i++) par ^= d[i];
    if (slot == 0) return 1'b0;
    if (slot <= db) return d[slot-1];
    if (PB == 1 && slot == db + 1) return par;
    return 1'b1;
  endfunction

  logic       ma_busy, ma_done, ma_odd, mb_busy, mb_done, mb_odd;
  int         ma_t, mb_t;
  logic [7:0] ma_dat, mb_dat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_busy <= 1'b0; ma_done <= 1'b0; ma_t <= 0; ma_dat <= '0; ma_odd <= 1'b0;
    end else if (!ma_busy) begin
      ma_done <= 1'b0;
      if (valid_a) begin
        ma_busy <= 1'b1; ma_t <= 0; ma_dat <= data_a; ma_odd <= odd_a;
      end
    end else if (ma_t == LEN_A - 1) begin
      ma_busy <= 1'b0; ma_done <= 1'b1;
      $display("frame A: data=0x%02h odd=%0d sent", ma_dat, ma_odd);
    end else begin
      ma_t <= ma_t + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb_busy <= 1'b0; mb_done <= 1'b0; mb_t <= 0; mb_dat <= '0; mb_odd <= 1'b0;
    end else if (!mb_busy) begin
      mb_done <= 1'b0;
      if (valid_b) begin
        mb_busy <= 1'b1; mb_t <= 0; mb_dat <= {1'b0, data_b}; mb_odd <= odd_b;
      end
    end else if (mb_t == LEN_B - 1) begin
      mb_busy <= 1'b0; mb_done <= 1'b1;
      $display("frame B: data=0x%02h odd=%0d sent", mb_dat, mb_odd);
    end else begin
      mb_t <= mb_t + 1;
    end
  end

  always @(posedge clk) begin
    #1;
    check("A.out",   32'(out_a),   32'(ma_busy ? slot_val(ma_dat, 8, ma_odd, ma_t / C) : 1'b1));
    check("A.ready", 32'(ready_a), 32'(!ma_busy));
    check("A.busy",  32'(busy_a),  32'(ma_busy));
    check("A.done",  32'(done_a),  32'(ma_done));
    check("B.out",   32'(out_b),   32'(mb_busy ? slot_val(mb_dat, 7, mb_odd, mb_t / C) : 1'b1));
    check("B.ready", 32'(ready_b), 32'(!mb_busy));
    check("B.busy",  32'(busy_b),  32'(mb_busy));
    check("B.done",  32'(done_b),  32'(mb_done));
  end

  function automatic logic get_out(input int w);
    return (w == 0) ? out_a : out_b;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic get_done(input int w);
    return (w == 0) ? done_a : done_b;
  endfunction

  task automatic drive(input int w, input logic v, input logic [7:0] d, input logic odd);
    if (w == 0) begin
      valid_a = v; data_a = d; odd_a = odd;
    end else begin
      valid_b = v; data_b = d[6:0]; odd_b = odd;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one frame and checks each slot level, done timing and busy length against literals.
  task automatic run_literal(input string name, input int w, input logic [7:0] d, input logic odd,
                             input logic [10:0] exp_bits, input int nslots, input int flen);
    logic [10:0] bits;
    int done_at, busy_cnt, done_cnt;
    bits = '0; done_at = -1; busy_cnt = 0; done_cnt = 0;
    @(negedge clk); drive(w, 1'b1, d, odd);
    @(posedge clk); #1;
    drive(w, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k <= flen + 2; k++) begin
      if (k % C == 1 && k < nslots * C) bits[k / C] = get_out(w);
      if (get_done(w)) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (get_busy(w)) busy_cnt++;
      @(posedge clk); #1;
    end
    check({name, ".slots"}, 32'(bits), 32'(exp_bits));
    check({name, ".done_at"}, done_at, flen);
    check({name, ".done_cnt"}, done_cnt, 1);
    check({name, ".busy_len"}, busy_cnt, flen);
  endtask

  initial begin
    logic [7:0] vec_d [5];
    logic [7:0] second;
    rst_n = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    wait_cycles(3);
    check("rst.out_a", 32'(out_a), 1);
    check("rst.ready_a", 32'(ready_a), 1);
    check("rst.busy_b", 32'(busy_b), 0);
    check("rst.done_b", 32'(done_b), 0);
    @(negedge clk); rst_n = 1'b1;
    wait_cycles(2);

`ifdef UART_TX_PARITY_EN
    run_literal("A5_even", 0, 8'hA5, 1'b0, 11'b10101001010, 11, LEN_A);
    run_literal("A5_odd",  0, 8'hA5, 1'b1, 11'b11101001010, 11, LEN_A);
    run_literal("B41",     1, 8'h41, 1'b0, 11'b11010000010, 11, LEN_B);
`else
    run_literal("A5_even", 0, 8'hA5, 1'b0, 11'b01101001010, 10, LEN_A);
    run_literal("A5_odd",  0, 8'hA5, 1'b1, 11'b01101001010, 10, LEN_A);
    run_literal("B41",     1, 8'h41, 1'b0, 11'b01110000010, 10, LEN_B);
`endif
    check("len.A", LEN_A, 40 + 4 * PB);

    vec_d = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h3C};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive(0, 1'b1, vec_d[i], 1'(i)); drive(1, 1'b1, vec_d[i] ^ 8'h55, 1'(i + 1));
      @(posedge clk); #1;
      drive(0, 1'b0, 8'h00, 1'b0); drive(1, 1'b0, 8'h00, 1'b0);
      wait_cycles(LEN_B + 2);
    end

    // Back-to-back with valid held: data changes right after the first accept.
    @(negedge clk); drive(0, 1'b1, 8'h5A, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b1, 8'h3C, 1'b0);
    second = '0;
    for (int k = 0; k < 2 * LEN_A + 2; k++) begin
      if (k == LEN_A) begin
        check("b2b.gap_out", 32'(out_a), 1);
        check("b2b.gap_done", 32'(done_a), 1);
      end
      if (k == LEN_A + 1) begin
        check("b2b.restart_out", 32'(out_a), 0);
        check("b2b.restart_busy", 32'(busy_a), 1);
      end
      if (k > LEN_A + C && k < LEN_A + 9 * C && (k - LEN_A - 1) % C == 1)
        second[(k - LEN_A - 1) / C - 1] = out_a;
      @(posedge clk); #1;
    end
    check("b2b.second_data", 32'(second), 32'h3C);
    drive(0, 1'b0, 8'h00, 1'b0);
    wait_cycles(LEN_A + 2);

    // valid pulses during a frame are ignored.
    @(negedge clk); drive(1, 1'b1, 8'h2A, 1'b1);
    @(posedge clk); #1;
    drive(1, 1'b0, 8'h00, 1'b0);
    wait_cycles(10);
    drive(1, 1'b1, 8'h55, 1'b0);
    wait_cycles(3);
    drive(1, 1'b0, 8'h00, 1'b0);
    wait_cycles(LEN_B);

    // Asynchronous reset in the middle of DATA.
    @(negedge clk); drive(0, 1'b1, 8'h0F, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00, 1'b0);
    wait_cycles(10);
    #2 rst_n = 1'b0;
    #1;
    check("arst.out", 32'(out_a), 1);
    check("arst.ready", 32'(ready_a), 1);
    check("arst.busy", 32'(busy_a), 0);
    check("arst.done", 32'(done_a), 0);
    drive(0, 1'b1, 8'hC3, 1'b1);
    wait_cycles(2);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst.first_accept", 32'(busy_a), 1);
    drive(0, 1'b0, 8'h00, 1'b0);
    wait_cycles(LEN_A + 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
